// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, codeword bit positions and the encoder function.
// Used by the transmit encoder and by receive-side checkers.
package hamming_pkg;

   localparam int CODE_W = 7;
   localparam int DATA_W = 4;

   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int D3 = 2;
   localparam int P4 = 3;
   localparam int D5 = 4;
   localparam int D6 = 5;
   localparam int D7 = 6;

   function automatic logic [CODE_W-1:0] ham74_encode(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] c;
      c     = '0;
      c[D3] = d[0];
      c[D5] = d[1];
      c[D6] = d[2];
      c[D7] = d[3];
      c[P1] = d[3] ^ d[1] ^ d[0];
      c[P2] = d[3] ^ d[2] ^ d[0];
      c[P4] = d[3] ^ d[2] ^ d[1];
      return c;
   endfunction

endpackage

// File: rtl/hamming74_encoder_tx_if.sv
// Nibble input and codeword output valid/ready channels of the Hamming(7,4) transmitter.
// The slave side is the encoder; the master side is the surrounding logic or bench.
interface hamming74_encoder_tx_if;
   import hamming_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_code;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_code
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_code
   );

endinterface

// File: rtl/hamming74_enc_core.sv
// Combinational nibble-to-codeword encoder, zero latency, no flow control of its own.
module hamming74_enc_core
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CODE_W-1:0] code_o
);

   assign code_o = ham74_encode(data_i);

endmodule

// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) transmit encoder with a DEPTH-entry codeword FIFO; HAMMING_ERR_INJ_EN adds bit-flip injection.
// One-cycle push-to-out latency, no bypass; in_ready drops when full or in reset, out_code held until popped.
module hamming74_encoder_tx
   import hamming_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   hamming74_encoder_tx_if.slave    bus,
   output logic [$clog2(DEPTH):0]   level,
`ifdef HAMMING_ERR_INJ_EN
   input  logic                     inj_arm,
   input  logic [2:0]               inj_pos,
   output logic [CNT_W-1:0]         inj_cnt,
`endif
   output logic [CNT_W-1:0]         sent_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [CNT_W-1:0]  sent_q, sent_d;

   logic [CODE_W-1:0] enc_code;
   logic [CODE_W-1:0] store_code;
   logic              push, pop;

   hamming74_enc_core u_enc (
      .data_i (bus.in_data),
      .code_o (enc_code)
   );

   assign bus.in_ready  = !rst && (level_q != FULL_LVL);
   assign bus.out_valid = (level_q != '0);
   assign bus.out_code  = bus.out_valid ? mem_q[rd_ptr_q] : '0;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

`ifdef HAMMING_ERR_INJ_EN
   logic [CNT_W-1:0]  inj_q, inj_d;
   logic [CODE_W-1:0] flip;
   logic              corrupt;

   // inj_pos counts codeword bits from 1; 0 means leave the codeword intact.
   always_comb begin
      flip    = '0;
      corrupt = inj_arm && (inj_pos != 3'd0);
      if (corrupt) begin
         flip[inj_pos - 3'd1] = 1'b1;
      end
      store_code = enc_code ^ flip;
      inj_d      = (push && corrupt) ? inj_q + CNT_W'(1) : inj_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inj_q <= '0;
      end else begin
         inj_q <= inj_d;
      end
   end

   assign inj_cnt = inj_q;
`else
   assign store_code = enc_code;
`endif

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      sent_d   = pop  ? sent_q + CNT_W'(1) : sent_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         sent_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         sent_q   <= sent_d;
      end
   end

   // Storage needs no reset: level gates every read, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= store_code;
      end
   end

   assign level    = level_q;
   assign sent_cnt = sent_q;

endmodule
